// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bus bundle for the shared-ALU arbiter.
//   req0_* / req1_* : per-requester valid/ready handshake carrying {a, b, op}
//   alu_a/alu_b/alu_s : operands and op select driven to the external ALU
//   alu_d/alu_c       : combinational result and carry returned by the ALU
//   rsp_*             : shared response channel (valid/ready) tagged with id
//   busy              : arbiter is not idle
// slave  = arbiter side, master = requesters/consumer/ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_s;
  logic [WIDTH-1:0] alu_d;
  logic             alu_c;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_d;
  logic             rsp_c;

  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_s,
    input  alu_d, alu_c,
    output rsp_valid, rsp_id, rsp_d, rsp_c,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_s,
    output alu_d, alu_c,
    input  rsp_valid, rsp_id, rsp_d, rsp_c,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with
// round-robin arbitration and a single outstanding operation.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_arbiter_if.slave (request ports, ALU drive/return, response)
// Flow: IDLE (grant) -> EXEC (ALU evaluates latched operands, result
// captured) -> RESP (held until rsp_ready) -> IDLE.
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             grant0;
  logic             grant1;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic             id_q;
  logic [WIDTH-1:0] d_q;
  logic             c_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // prio names the port that wins when both are valid; an uncontended
  // grant still hands priority to the other port.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    unique case (state)
      IDLE: begin
        grant0 = bus.req0_valid & (~prio | ~bus.req1_valid);
        grant1 = bus.req1_valid & ( prio | ~bus.req0_valid);
        if (grant0 | grant1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      id_q <= 1'b0;
      d_q  <= '0;
      c_q  <= 1'b0;
    end else begin
      if (grant0) begin
        a_q  <= bus.req0_a;
        b_q  <= bus.req0_b;
        op_q <= bus.req0_op;
        id_q <= 1'b0;
        prio <= 1'b1;
      end else if (grant1) begin
        a_q  <= bus.req1_a;
        b_q  <= bus.req1_b;
        op_q <= bus.req1_op;
        id_q <= 1'b1;
        prio <= 1'b0;
      end
      if (state == EXEC) begin
        d_q <= bus.alu_d;
        c_q <= bus.alu_c;
      end
    end
  end

  // Readies are masked during reset so every output reads 0 while rst is high.
  assign bus.req0_ready = grant0 & ~rst;
  assign bus.req1_ready = grant1 & ~rst;

  // Operand registers feed the ALU directly and keep their last values in IDLE.
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_s     = op_q;

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_d     = d_q;
  assign bus.rsp_c     = c_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int WIDTH = 8;
  localparam int OPW   = 3;

  logic clk = 1'b0;
  logic rst;

  alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: 0 add, 1 sub (c = borrow), 2 and, 3 or, 4 xor,
  // 5 shl (c = msb out), 6 shr (c = lsb out), 7 not a.
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    logic [7:0] t;
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: begin t = a - b; return {(a < b), t}; end
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: begin t = a << 1; return {a[7], t}; end
      3'd6: begin t = a >> 1; return {a[0], t}; end
      default: return {1'b0, ~a};
    endcase
  endfunction

  always_comb {bus.alu_c, bus.alu_d} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_s);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        id;
    logic [7:0]  d;
    logic        c;
    int unsigned cyc;
  } exp_t;

  exp_t sbq[$];

  // Arbitration model: one outstanding op, round-robin pointer that moves
  // to the other port after every grant.
  logic       exp_busy = 1'b0;
  logic       exp_prio = 1'b0;
  logic [7:0] last_a = '0, last_b = '0;
  logic [2:0] last_op = '0;

  always @(negedge clk) begin
    logic       was_busy;
    int         g;
    logic [8:0] r;
    exp_t       e;
    if (rst) begin
      exp_busy = 1'b0;
      exp_prio = 1'b0;
      sbq.delete();
      last_a   = '0;
      last_b   = '0;
      last_op  = '0;
    end else begin
      was_busy = exp_busy;
      chk("busy", 32'(bus.busy), 32'(was_busy));
      chk("alu_a_hold", 32'(bus.alu_a), 32'(last_a));
      chk("alu_b_hold", 32'(bus.alu_b), 32'(last_b));
      chk("alu_s_hold", 32'(bus.alu_s), 32'(last_op));
      if (was_busy) begin
        chk("ready0_busy", 32'(bus.req0_ready), 32'd0);
        chk("ready1_busy", 32'(bus.req1_ready), 32'd0);
        if (bus.rsp_valid && bus.rsp_ready) exp_busy = 1'b0;
      end else begin
        g = -1;
        if (bus.req0_valid && bus.req1_valid) g = exp_prio ? 1 : 0;
        else if (bus.req0_valid) g = 0;
        else if (bus.req1_valid) g = 1;
        chk("ready0", 32'(bus.req0_ready), 32'(g == 0));
        chk("ready1", 32'(bus.req1_ready), 32'(g == 1));
        if (g >= 0) begin
          if (g == 0) begin
            last_a = bus.req0_a; last_b = bus.req0_b; last_op = bus.req0_op;
          end else begin
            last_a = bus.req1_a; last_b = bus.req1_b; last_op = bus.req1_op;
          end
          r     = alu_ref(last_a, last_b, last_op);
          e.id  = (g == 1);
          e.d   = r[7:0];
          e.c   = r[8];
          e.cyc = cyc;
          sbq.push_back(e);
          exp_prio = (g == 0);
          exp_busy = 1'b1;
        end
      end
    end
  end

  // Response monitor: compares every valid cycle against the queue head,
  // pops on handshake.
  logic cont = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      cont = 1'b0;
    end else if (bus.rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        if (!cont) chk("latency", cyc - sbq[0].cyc, 32'd2);
        chk("rsp_id", 32'(bus.rsp_id), 32'(sbq[0].id));
        chk("rsp_d",  32'(bus.rsp_d),  32'(sbq[0].d));
        chk("rsp_c",  32'(bus.rsp_c),  32'(sbq[0].c));
        if (bus.rsp_ready) void'(sbq.pop_front());
      end
      cont = !bus.rsp_ready;
    end else begin
      cont = 1'b0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 30) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the response handshake.
  task automatic do_op(input logic port, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [7:0] exp_d, input logic exp_c);
    int n;
    if (!port) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(port ? bus.req1_ready : bus.req0_ready) && n < 20);
    if (n >= 20) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("exec_alu_s", 32'(bus.alu_s), 32'(op));
    chk("exec_busy", 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    if (n >= 20) chk("rsp_timeout", 32'd1, 32'd0);
    chk("dir_rsp_d",  32'(bus.rsp_d),  32'(exp_d));
    chk("dir_rsp_c",  32'(bus.rsp_c),  32'(exp_c));
    chk("dir_rsp_id", 32'(bus.rsp_id), 32'(port));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready  = 1'b1;
    #12;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_alu_a",     32'(bus.alu_a),     32'd0);
    chk("rst_rsp_d",     32'(bus.rsp_d),     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed operations.
    do_op(1'b0, 8'h05, 8'h03, 3'b000, 8'h08, 1'b0);
    chk("idle_after_op", 32'(bus.busy), 32'd0);
    do_op(1'b1, 8'h03, 8'h05, 3'b001, 8'hFE, 1'b1);
    do_op(1'b0, 8'hFF, 8'h01, 3'b000, 8'h00, 1'b1);
    do_op(1'b0, 8'h0F, 8'h00, 3'b111, 8'hF0, 1'b0);

    // Contention: both requesters valid continuously.
    bus.req0_valid = 1'b1; bus.req0_a = 8'h11; bus.req0_b = 8'h22; bus.req0_op = 3'd0;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h90; bus.req1_b = 8'h0F; bus.req1_op = 3'd2;
    repeat (15) @(posedge clk);
    #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_idle();

    // Backpressure with port 0 waiting behind a held response.
    bus.rsp_ready  = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 8'hC0; bus.req1_b = 8'h50; bus.req1_op = 3'd0;
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 8'h81; bus.req0_b = 8'h00; bus.req0_op = 3'd5;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_d",     32'(bus.rsp_d),     32'h10);
      chk("bp_ready0",     32'(bus.req0_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_accept", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_idle();

    // Reset while in EXEC.
    bus.req1_valid = 1'b1; bus.req1_a = 8'h33; bus.req1_b = 8'h44; bus.req1_op = 3'd3;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bus.req1_ready && n < 20);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",      32'(bus.busy),      32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_alu_a",     32'(bus.alu_a),     32'd0);
    chk("mid_rst_alu_s",     32'(bus.alu_s),     32'd0);
    chk("mid_rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_grant0", 32'(bus.req0_ready), 32'd1);
    chk("post_rst_grant1", 32'(bus.req1_ready), 32'd0);
    repeat (8) @(posedge clk);
    #1;

    // Randomized traffic.
    repeat (500) begin
      bus.req0_valid = ($urandom_range(0, 9) < 6);
      bus.req1_valid = ($urandom_range(0, 9) < 6);
      bus.req0_a  = 8'($urandom); bus.req0_b = 8'($urandom); bus.req0_op = 3'($urandom);
      bus.req1_a  = 8'($urandom); bus.req1_b = 8'($urandom); bus.req1_op = 3'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU between two requesters (port 0, port 1) using round-robin arbitration.
- Each requester issues {A, B, op} with a valid/ready handshake. Results return on a single shared response channel, tagged with the requester id.
- The block holds at most one outstanding operation. It drives the ALU's A/B/S inputs and samples its D/C outputs.

Parameters:
- WIDTH, 8, operand and result width; must match the ALU datapath.
- OPW, 3, op-select width; must match the ALU S input.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req0_op  in  OPW  requester 0 op select
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as port 0, for requester 1
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_s  out  OPW  to ALU S
- alu_d  in  WIDTH  from ALU D (combinational)
- alu_c  in  1  from ALU C (carry/borrow/bit 8)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result
- rsp_d  out  WIDTH  result
- rsp_c  out  1  carry/ninth bit
- busy  out  1  state != IDLE

Behaviour:
- State machine with three states: IDLE, EXEC, RESP. Reset puts the block in IDLE.
- Reset values (asynchronous, immediate on rst=1):
  - state=IDLE, prio=0
  - operand/op/id registers = 0
  - result registers = 0
  - outputs: rsp_valid=0, busy=0, alu_a/alu_b/alu_s=0, rsp_d/rsp_c/rsp_id=0
- Ready generation (combinational, only in IDLE):
  - req0_ready = valid0 & (prio==0 | !valid1)
  - req1_ready = valid1 & (prio==1 | !valid0)
  - At most one ready is asserted per cycle. Both readies are 0 in EXEC and RESP.
- Cycle T, IDLE with a handshake on port k:
  - Latch a, b, op from port k and set id=k.
  - prio <= ~k.
  - Go to EXEC.
- With no valid in IDLE: stay in IDLE; prio is unchanged.
- prio changes only on a grant. An uncontended grant also flips it (e.g. grant to 0 sets prio=1).
- Cycle T+1, EXEC:
  - alu_a/alu_b/alu_s present the latched registers.
  - At the clock edge ending T+1, alu_d and alu_c are captured into the result registers. Go to RESP.
- Cycle T+2, RESP:
  - rsp_valid=1; rsp_d, rsp_c, rsp_id come from registers and stay stable while rsp_valid=1.
  - On rsp_valid & rsp_ready, go to IDLE. rsp_valid drops the next cycle.
  - If rsp_ready=0, hold RESP indefinitely.
- Latency and throughput:
  - Acceptance to rsp_valid is 2 cycles.
  - The earliest next acceptance is the cycle after the response handshake, so sustained throughput is 1 operation per 3 cycles.
- alu_a/alu_b/alu_s hold their last latched values at all times outside reset; they do not return to 0 in IDLE.
- Requester inputs are sampled only on that port's handshake cycle. Changes at other times are ignored.
- The block does not interpret ops. All 8 codes are passed through, and alu_c is reported unmodified.
- Reset mid-operation (EXEC or RESP): the pending operation is discarded, no response is produced, and prio returns to 0.

Test Plan:
- Single op: req0 add a=0x05 b=0x03 op=000 accepted at T, rsp_ready=1 -> at T+2 rsp_valid=1, rsp_d=0x08, rsp_c=0, rsp_id=0; busy=1 in T+1..T+2; IDLE at T+3.
- Borrow/overflow: req1 sub 0x03-0x05 (op=001) -> rsp_d=0xFE, rsp_c=1, rsp_id=1. Then add 0xFF+0x01 -> rsp_d=0x00, rsp_c=1.
- Contention: both valid continuously, prio=0 after reset -> grants alternate 0,1,0,1. Each grant's rsp_id matches, and the non-granted ready stays 0.
- Backpressure: in RESP, hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_d stay stable and both req readies stay 0. Releasing rsp_ready gives IDLE on the next cycle, with the next acceptance possible in that cycle.
- Reset in EXEC: assert rst asynchronously (mid-cycle) -> all outputs go to 0 immediately, no rsp_valid after release, and the next contention grants port 0.
- Op pass-through: req0 op=111 a=0x0F -> alu_s=111 during EXEC, rsp_d=0xF0 with alu_c as returned by the ALU.
